// File: rtl/merge_sched_3x1_pkg.sv
// Shared types and helpers for the three-lane round-robin merge scheduler.
package merge_pkg;

    localparam int unsigned LANES = 3;

    typedef logic [1:0] lane_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } merge_st_t;

    // First non-empty lane scanning ptr+1, ptr+2, ptr (mod LANES); returns ptr when none.
    function automatic lane_id_t rr_next(input lane_id_t ptr, input logic [LANES-1:0] mask);
        lane_id_t res;
        lane_id_t cand;
        res = ptr;
        for (int i = int'(LANES); i >= 1; i--) begin
            cand = lane_id_t'((int'(ptr) + i) % int'(LANES));
            if (mask[cand]) begin
                res = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/merge_sched_3x1_lane_fifo.sv
// Per-lane FIFO: register storage, natural-wrap pointers, occupancy count and
// a freeze flag decoded directly from the registered count.
module merge_lane_fifo #(
    parameter int unsigned DW            = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned FREEZE_MARGIN = 1
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     freeze
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    // A full lane still takes a write when it is popped in the same cycle.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign dout   = r_mem[r_rd_ptr];
    assign cnt    = r_cnt;
    assign full   = (r_cnt == CW'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign freeze = ((CW'(DEPTH) - r_cnt) <= CW'(FREEZE_MARGIN));

endmodule

// File: rtl/merge_sched_3x1.sv
// Round-robin merge of three producer lanes into one valid/ready stream.
// Define MERGE_STATS_EN to add per-lane saturating pop counters on gnt_cnt.
module merge_sched_3x1
    import merge_pkg::*;
#(
    parameter int unsigned DW            = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned FREEZE_MARGIN = 1
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic [2:0]       wen,
    input  logic [DW-1:0]    i_data0,
    input  logic [DW-1:0]    i_data1,
    input  logic [DW-1:0]    i_data2,
    output logic [2:0]       freeze_o,
    output logic [2:0]       ovf_o,
    input  logic             o_ready,
    output logic             valid,
    output logic [DW-1:0]    o_data,
    output lane_id_t         o_src
`ifdef MERGE_STATS_EN
    ,
    output logic [15:0]      gnt_cnt [LANES]
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    merge_st_t          r_state;
    logic               r_valid;
    logic [DW-1:0]      r_data;
    lane_id_t           r_src;
    lane_id_t           r_rr_ptr;
    logic [LANES-1:0]   r_ovf;

    logic [DW-1:0]      w_din   [LANES];
    logic [DW-1:0]      w_dout  [LANES];
    logic [CW-1:0]      w_cnt   [LANES];
    logic [LANES-1:0]   w_full;
    logic [LANES-1:0]   w_empty;
    logic [LANES-1:0]   w_freeze;
    logic [LANES-1:0]   w_nonempty;
    logic [LANES-1:0]   w_pop;
    lane_id_t           w_gnt;
    logic               w_take;
    logic               w_do_pop;
    logic               w_unused_cnt;

    assign w_din[0] = i_data0;
    assign w_din[1] = i_data1;
    assign w_din[2] = i_data2;

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        merge_lane_fifo #(
            .DW            (DW),
            .DEPTH         (DEPTH),
            .FREEZE_MARGIN (FREEZE_MARGIN)
        ) u_fifo (
            .clk_i  (clk_i),
            .reset  (reset),
            .push   (wen[k]),
            .pop    (w_pop[k]),
            .din    (w_din[k]),
            .dout   (w_dout[k]),
            .cnt    (w_cnt[k]),
            .full   (w_full[k]),
            .empty  (w_empty[k]),
            .freeze (w_freeze[k])
        );
    end

    // Occupancy is consumed through the lane's decoded flags.
    assign w_unused_cnt = ^{w_cnt[0], w_cnt[1], w_cnt[2]};

    // Grant sees only registered occupancy, so same-cycle arrivals never bypass.
    assign w_nonempty = ~w_empty;
    assign w_gnt      = rr_next(r_rr_ptr, w_nonempty);
    assign w_take     = (r_state == IDLE) || o_ready;
    assign w_do_pop   = w_take && (|w_nonempty);
    assign w_pop      = w_do_pop ? (LANES'(1) << w_gnt) : '0;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= lane_id_t'(2);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_do_pop) begin
                        r_state  <= SEND;
                        r_valid  <= 1'b1;
                        r_data   <= w_dout[w_gnt];
                        r_src    <= w_gnt;
                        r_rr_ptr <= w_gnt;
                    end
                end
                SEND: begin
                    if (o_ready) begin
                        if (w_do_pop) begin
                            r_data   <= w_dout[w_gnt];
                            r_src    <= w_gnt;
                            r_rr_ptr <= w_gnt;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // A write is lost only when the lane is full and not drained this cycle.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | (wen & w_full & ~w_pop);
        end
    end

`ifdef MERGE_STATS_EN
    for (genvar k = 0; k < int'(LANES); k++) begin : g_stats
        always_ff @(posedge clk_i) begin
            if (reset) begin
                gnt_cnt[k] <= '0;
            end else if (w_pop[k] && (gnt_cnt[k] != 16'hFFFF)) begin
                gnt_cnt[k] <= gnt_cnt[k] + 16'd1;
            end
        end
    end
`endif

    assign valid    = r_valid;
    assign o_data   = r_data;
    assign o_src    = r_src;
    assign ovf_o    = r_ovf;
    assign freeze_o = w_freeze;

endmodule

// File: tb/tb_merge_sched_3x1.sv
// Directed bench for merge_sched_3x1 with a queue-based reference model.
module tb_merge_sched_3x1;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 1;

    logic        clk_i = 1'b0;
    logic        reset;
    logic [2:0]  wen;
    logic [7:0]  d0, d1, d2;
    logic        o_ready;
    logic [2:0]  freeze_o;
    logic [2:0]  ovf_o;
    logic        valid;
    logic [7:0]  o_data;
    logic [1:0]  o_src;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [7:0] exp_rr [6] = '{8'h11, 8'h21, 8'h31, 8'h12, 8'h22, 8'h32};

    always #5 clk_i = ~clk_i;

    merge_sched_3x1 dut (
        .clk_i    (clk_i),
        .reset    (reset),
        .wen      (wen),
        .i_data0  (d0),
        .i_data1  (d1),
        .i_data2  (d2),
        .freeze_o (freeze_o),
        .ovf_o    (ovf_o),
        .o_ready  (o_ready),
        .valid    (valid),
        .o_data   (o_data),
        .o_src    (o_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lane queues, output register and round-robin pointer.
    logic [7:0] mq [3][$];
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_src;
    int         m_rr;
    logic [2:0] m_ovf;

    always @(posedge clk_i) begin : model
        int g;
        int l;
        logic [7:0] din [3];
        din[0] = d0;
        din[1] = d1;
        din[2] = d2;
        if (reset) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_src   = 2'd0;
            m_rr    = 2;
            m_ovf   = 3'b000;
        end else begin
            if (!m_valid || o_ready) begin
                g = -1;
                for (int i = 1; i <= 3; i++) begin
                    l = (m_rr + i) % 3;
                    if (g < 0 && mq[l].size() > 0) g = l;
                end
                if (g >= 0) begin
                    m_data  = mq[g].pop_front();
                    m_src   = 2'(g);
                    m_valid = 1'b1;
                    m_rr    = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (wen[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(din[k]);
                    else m_ovf[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_i) begin : compare
        logic [2:0] exp_frz;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) exp_frz[k] = ((DEPTH - mq[k].size()) <= MARGIN);
            chk("model_valid", 32'(valid), 32'(m_valid));
            chk("model_freeze", 32'(freeze_o), 32'(exp_frz));
            chk("model_ovf", 32'(ovf_o), 32'(m_ovf));
            if (m_valid) begin
                chk("model_data", 32'(o_data), 32'(m_data));
                chk("model_src", 32'(o_src), 32'(m_src));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic idle_in();
        wen = 3'b000;
        d0  = 8'h00;
        d1  = 8'h00;
        d2  = 8'h00;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        o_ready = 1'b0;
        idle_in();
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        o_ready = 1'b0;
        idle_in();
        @(negedge clk_i);
        cyc(2);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset values
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_src", 32'(o_src), 32'd0);
        chk("rst_freeze", 32'(freeze_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);

        // Single beat latency
        o_ready = 1'b1;
        wen = 3'b001; d0 = 8'hA0;
        cyc(1);
        idle_in();
        chk("lat_n1_valid", 32'(valid), 32'd0);
        cyc(1);
        chk("lat_n2_valid", 32'(valid), 32'd1);
        chk("lat_n2_data", 32'(o_data), 32'hA0);
        chk("lat_n2_src", 32'(o_src), 32'd0);
        cyc(1);
        chk("lat_n3_valid", 32'(valid), 32'd0);

        // Round-robin order across three preloaded lanes
        do_reset();
        wen = 3'b111; d0 = 8'h11; d1 = 8'h21; d2 = 8'h31;
        cyc(1);
        d0 = 8'h12; d1 = 8'h22; d2 = 8'h32;
        cyc(1);
        idle_in();
        o_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_valid", 32'(valid), 32'd1);
            chk("rr_data", 32'(o_data), 32'(exp_rr[i]));
            cyc(1);
        end
        chk("rr_done", 32'(valid), 32'd0);

        // Backpressure hold
        do_reset();
        wen = 3'b010; d1 = 8'h55;
        cyc(1);
        d1 = 8'h66;
        cyc(1);
        idle_in();
        for (int i = 0; i < 10; i++) begin
            chk("hold_data", 32'(o_data), 32'h55);
            chk("hold_src", 32'(o_src), 32'd1);
            cyc(1);
        end
        o_ready = 1'b1;
        cyc(1);
        chk("hold_next_valid", 32'(valid), 32'd1);
        chk("hold_next_data", 32'(o_data), 32'h66);
        cyc(1);
        chk("hold_empty", 32'(valid), 32'd0);

        // Freeze and overflow on lane 2 while output is blocked
        do_reset();
        wen = 3'b001; d0 = 8'h0F;
        cyc(1);
        idle_in();
        wen = 3'b100; d2 = 8'd1;
        cyc(1);
        d2 = 8'd2;
        cyc(1);
        chk("frz_cnt2", 32'(freeze_o[2]), 32'd0);
        d2 = 8'd3;
        cyc(1);
        chk("frz_cnt3", 32'(freeze_o[2]), 32'd1);
        d2 = 8'd4;
        cyc(1);
        chk("ovf_cnt4", 32'(ovf_o[2]), 32'd0);
        d2 = 8'd5;
        cyc(1);
        chk("ovf_drop", 32'(ovf_o[2]), 32'd1);
        idle_in();
        o_ready = 1'b1;
        chk("ovf_head", 32'(o_data), 32'h0F);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(o_data), 32'(i + 1));
            chk("drain_src", 32'(o_src), 32'd2);
            cyc(1);
        end
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_frz", 32'(freeze_o[2]), 32'd0);
        chk("drain_ovf_sticky", 32'(ovf_o[2]), 32'd1);

        // Write into a full lane on its pop cycle
        do_reset();
        wen = 3'b010; d1 = 8'h77;
        cyc(1);
        idle_in();
        wen = 3'b001;
        d0 = 8'hC1; cyc(1);
        d0 = 8'hC2; cyc(1);
        d0 = 8'hC3; cyc(1);
        d0 = 8'hC4; cyc(1);
        chk("full_frz", 32'(freeze_o[0]), 32'd1);
        chk("full_head", 32'(o_data), 32'h77);
        o_ready = 1'b1;
        d0 = 8'hE5;
        cyc(1);
        idle_in();
        chk("pp_data", 32'(o_data), 32'hC1);
        chk("pp_ovf", 32'(ovf_o[0]), 32'd0);
        chk("pp_frz", 32'(freeze_o[0]), 32'd1);
        cyc(4);
        chk("pp_last", 32'(o_data), 32'hE5);
        cyc(1);
        chk("pp_done", 32'(valid), 32'd0);

        // Reset in the middle of traffic
        do_reset();
        wen = 3'b111; d0 = 8'h01; d1 = 8'h02; d2 = 8'h03;
        cyc(1);
        d0 = 8'h04; d1 = 8'h05; d2 = 8'h06;
        cyc(1);
        wen = 3'b001; d0 = 8'h07;
        cyc(1);
        idle_in();
        chk("mid_valid", 32'(valid), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_frz", 32'(freeze_o), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_o), 32'd0);
        o_ready = 1'b1;
        wen = 3'b011; d0 = 8'hB0; d1 = 8'hB1;
        cyc(1);
        idle_in();
        chk("post_idle", 32'(valid), 32'd0);
        cyc(1);
        chk("post_first_src", 32'(o_src), 32'd0);
        chk("post_first_data", 32'(o_data), 32'hB0);
        cyc(1);
        chk("post_second_src", 32'(o_src), 32'd1);
        chk("post_second_data", 32'(o_data), 32'hB1);
        cyc(1);
        chk("post_done", 32'(valid), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
